// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the single-bus control unit: opcodes, step states,
// the strobe bundle and the opcode classifier.
package cpu_ctrl_pkg;

    localparam int OP_W  = 5;
    localparam int CNT_W = 8;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_LD   = 5'b00000;
    localparam opcode_t OP_ST   = 5'b00010;
    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110;
    localparam opcode_t OP_SHR  = 5'b00111;
    localparam opcode_t OP_SHL  = 5'b01000;
    localparam opcode_t OP_ROR  = 5'b01001;
    localparam opcode_t OP_ROL  = 5'b01010;
    localparam opcode_t OP_ADDI = 5'b01100;
    localparam opcode_t OP_MUL  = 5'b01111;
    localparam opcode_t OP_DIV  = 5'b10000;
    localparam opcode_t OP_MFHI = 5'b11000;
    localparam opcode_t OP_MFLO = 5'b11001;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    // Steps T0..T7 encode as their step number so Tstep is the state itself.
    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_T7   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU, CLS_ADDI, CLS_MULDIV, CLS_MFHI, CLS_MFLO,
        CLS_LD, CLS_ST, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic    pc_out;
        logic    zlow_out;
        logic    zhigh_out;
        logic    mdr_out;
        logic    hi_out;
        logic    lo_out;
        logic    c_out;
        logic    ba_out;
        logic    r_out;
        logic    mar_in;
        logic    pc_in;
        logic    mdr_in;
        logic    ir_in;
        logic    y_in;
        logic    z_in;
        logic    hi_in;
        logic    lo_in;
        logic    r_in;
        logic    gra;
        logic    grb;
        logic    grc;
        logic    inc_pc;
        logic    read;
        logic    write;
        opcode_t op;
    } strobes_t;

    // Groups opcodes by the execute sequence they share.
    function automatic op_class_t classify(input opcode_t opc);
        op_class_t c;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: c = CLS_ALU;
            OP_ADDI:                        c = CLS_ADDI;
            OP_MUL, OP_DIV:                 c = CLS_MULDIV;
            OP_MFHI:                        c = CLS_MFHI;
            OP_MFLO:                        c = CLS_MFLO;
            OP_LD:                          c = CLS_LD;
            OP_ST:                          c = CLS_ST;
            OP_NOP:                         c = CLS_NOP;
            OP_HALT:                        c = CLS_HALT;
            default:                        c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_sequencer_step_decoder.sv
// Pure combinational map from (step, opcode) to the datapath strobe bundle.
module step_decoder
    import cpu_ctrl_pkg::*;
(
    input  state_t   state,
    input  opcode_t  opcode,
    output strobes_t strobes,
    output logic     illegal
);

    op_class_t cls;

    // Decode the strobes for the current step; everything defaults to idle.
    always_comb begin
        strobes = '0;
        illegal = 1'b0;
        cls     = classify(opcode);
        case (state)
            ST_T0: begin
                strobes.pc_out = 1'b1; strobes.mar_in = 1'b1;
                strobes.inc_pc = 1'b1; strobes.z_in   = 1'b1;
            end
            ST_T1: begin
                strobes.zlow_out = 1'b1; strobes.pc_in  = 1'b1;
                strobes.read     = 1'b1; strobes.mdr_in = 1'b1;
            end
            ST_T2: begin
                strobes.mdr_out = 1'b1; strobes.ir_in = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_ALU, CLS_ADDI: begin
                        strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    CLS_MFHI: begin
                        strobes.gra = 1'b1; strobes.r_in = 1'b1; strobes.hi_out = 1'b1;
                    end
                    CLS_MFLO: begin
                        strobes.gra = 1'b1; strobes.r_in = 1'b1; strobes.lo_out = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_in = 1'b1;
                    end
                    CLS_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_ALU: begin
                        strobes.grc = 1'b1; strobes.r_out = 1'b1;
                        strobes.z_in = 1'b1; strobes.op = opcode;
                    end
                    CLS_ADDI, CLS_LD, CLS_ST: begin
                        strobes.c_out = 1'b1; strobes.z_in = 1'b1; strobes.op = OP_ADD;
                    end
                    CLS_MULDIV: begin
                        strobes.grb = 1'b1; strobes.r_out = 1'b1;
                        strobes.z_in = 1'b1; strobes.op = opcode;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_ALU, CLS_ADDI: begin
                        strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        strobes.zlow_out = 1'b1; strobes.lo_in = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        strobes.zlow_out = 1'b1; strobes.mar_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CLS_MULDIV: begin
                        strobes.zhigh_out = 1'b1; strobes.hi_in = 1'b1;
                    end
                    CLS_LD: begin
                        strobes.read = 1'b1; strobes.mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.mdr_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CLS_LD: begin
                        strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    CLS_ST: strobes.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0..T2, execute T3..T7 per opcode,
// memory-step stalls with timeout, and halt/run control.
// Tstep shows the state encoding, so it reads 8 while halted.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW          = OP_W,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic           Clock,
    input  logic           Reset_n,
    input  logic [31:0]    IR,
    input  logic           MemReady,
    input  logic           Stop,
    input  logic           Start,
    output logic           PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, BAout, Rout,
    output logic           MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
    output logic           GRA, GRB, GRC,
    output logic           IncPC, Read, Write,
    output logic [OPW-1:0] operation,
    output logic           Run,
    output logic [3:0]     Tstep,
    output logic           IllegalOp,
    output logic           MemFault
);

    state_t           state, state_next;
    opcode_t          opcode_q, opcode_cur;
    op_class_t        cls;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_step, timeout, instr_end, mem_fault_q;
    strobes_t         strb_dec, strb;
    logic             illegal_dec;
    logic             unused_ir;

    // IR is freshly loaded during T3, so T3 decodes it directly; later steps use the latch.
    assign opcode_cur = (state == ST_T3) ? IR[31:27] : opcode_q;
    assign cls        = classify(opcode_cur);
    assign unused_ir  = ^IR[26:0];

    assign mem_step = (state == ST_T1)
                   || (state == ST_T6 && cls == CLS_LD)
                   || (state == ST_T7 && cls == CLS_ST);
    assign timeout  = mem_step && !MemReady && (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));

    // Next-state: step sequencing, memory stalls, instruction-end Stop sampling, timeout.
    always_comb begin
        state_next = state;
        instr_end  = 1'b0;
        case (state)
            ST_T0: state_next = ST_T1;
            ST_T1: if (MemReady) state_next = ST_T2;
            ST_T2: state_next = ST_T3;
            ST_T3: begin
                case (cls)
                    CLS_HALT: state_next = ST_HALT;
                    CLS_ALU, CLS_ADDI, CLS_MULDIV, CLS_LD, CLS_ST: state_next = ST_T4;
                    default: instr_end = 1'b1;
                endcase
            end
            ST_T4: state_next = ST_T5;
            ST_T5: begin
                if (cls == CLS_ALU || cls == CLS_ADDI) instr_end = 1'b1;
                else                                   state_next = ST_T6;
            end
            ST_T6: begin
                case (cls)
                    CLS_LD: if (MemReady) state_next = ST_T7;
                    CLS_ST: state_next = ST_T7;
                    default: instr_end = 1'b1;
                endcase
            end
            ST_T7: begin
                if (cls != CLS_ST || MemReady) instr_end = 1'b1;
            end
            ST_HALT: if (Start) state_next = ST_T0;
            default: state_next = ST_T0;
        endcase
        if (instr_end) state_next = Stop ? ST_HALT : ST_T0;
        if (timeout)   state_next = ST_HALT;
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= ST_T0;
        else          state <= state_next;
    end

    // Opcode latch, captured as T3 completes for use in T4..T7.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)             opcode_q <= '0;
        else if (state == ST_T3)  opcode_q <= IR[31:27];
    end

    // Memory wait counter: cleared whenever the step changes, counts stalled cycles.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)                    wait_cnt <= '0;
        else if (state_next != state)    wait_cnt <= '0;
        else if (mem_step && !MemReady)  wait_cnt <= wait_cnt + 1'b1;
    end

    // Sticky memory fault; cleared only by a Start that leaves HALT.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)                         mem_fault_q <= 1'b0;
        else if (timeout)                     mem_fault_q <= 1'b1;
        else if (state == ST_HALT && Start)   mem_fault_q <= 1'b0;
    end

    step_decoder u_step_decoder (
        .state   (state),
        .opcode  (opcode_cur),
        .strobes (strb_dec),
        .illegal (illegal_dec)
    );

    // While reset is asserted nothing drives the datapath, whatever the state decodes to.
    assign strb = Reset_n ? strb_dec : '0;

    assign PCout     = strb.pc_out;
    assign Zlowout   = strb.zlow_out;
    assign ZHighout  = strb.zhigh_out;
    assign MDRout    = strb.mdr_out;
    assign HIout     = strb.hi_out;
    assign LOout     = strb.lo_out;
    assign Cout      = strb.c_out;
    assign BAout     = strb.ba_out;
    assign Rout      = strb.r_out;
    assign MARin     = strb.mar_in;
    assign PCin      = strb.pc_in;
    assign MDRin     = strb.mdr_in;
    assign IRin      = strb.ir_in;
    assign Yin       = strb.y_in;
    assign Zin       = strb.z_in;
    assign HIin      = strb.hi_in;
    assign LOin      = strb.lo_in;
    assign Rin       = strb.r_in;
    assign GRA       = strb.gra;
    assign GRB       = strb.grb;
    assign GRC       = strb.grc;
    assign IncPC     = strb.inc_pc;
    assign Read      = strb.read;
    assign Write     = strb.write;
    assign operation = OPW'(strb.op);
    assign IllegalOp = Reset_n & illegal_dec;
    assign Run       = (state != ST_HALT);
    assign Tstep     = state;
    assign MemFault  = mem_fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, ALU, MFLO, LD with stall,
// memory timeout, illegal opcode with Stop, HALT opcode and Start handling.
module tb_control_sequencer;

    localparam int W = 33;

    // Strobe bit positions in the observed vector.
    localparam logic [23:0] B_PCOUT  = 24'd1 << 23;
    localparam logic [23:0] B_ZLOW   = 24'd1 << 22;
    localparam logic [23:0] B_ZHIGH  = 24'd1 << 21;
    localparam logic [23:0] B_MDROUT = 24'd1 << 20;
    localparam logic [23:0] B_HIOUT  = 24'd1 << 19;
    localparam logic [23:0] B_LOOUT  = 24'd1 << 18;
    localparam logic [23:0] B_COUT   = 24'd1 << 17;
    localparam logic [23:0] B_BAOUT  = 24'd1 << 16;
    localparam logic [23:0] B_ROUT   = 24'd1 << 15;
    localparam logic [23:0] B_MARIN  = 24'd1 << 14;
    localparam logic [23:0] B_PCIN   = 24'd1 << 13;
    localparam logic [23:0] B_MDRIN  = 24'd1 << 12;
    localparam logic [23:0] B_IRIN   = 24'd1 << 11;
    localparam logic [23:0] B_YIN    = 24'd1 << 10;
    localparam logic [23:0] B_ZIN    = 24'd1 << 9;
    localparam logic [23:0] B_HIIN   = 24'd1 << 8;
    localparam logic [23:0] B_LOIN   = 24'd1 << 7;
    localparam logic [23:0] B_RIN    = 24'd1 << 6;
    localparam logic [23:0] B_GRA    = 24'd1 << 5;
    localparam logic [23:0] B_GRB    = 24'd1 << 4;
    localparam logic [23:0] B_GRC    = 24'd1 << 3;
    localparam logic [23:0] B_INCPC  = 24'd1 << 2;
    localparam logic [23:0] B_READ   = 24'd1 << 1;
    localparam logic [23:0] B_WRITE  = 24'd1 << 0;

    localparam logic [23:0] S_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [23:0] S_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
    localparam logic [23:0] S_T2 = B_MDROUT | B_IRIN;

    localparam logic [31:0] IR_ADD  = 32'h1A00_0000;
    localparam logic [31:0] IR_MFLO = 32'hC880_0000;
    localparam logic [31:0] IR_LD   = 32'h0080_0000;
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;

    logic        Clock, Reset_n, MemReady, Stop, Start;
    logic [31:0] IR;
    logic        PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, BAout, Rout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin;
    logic        GRA, GRB, GRC, IncPC, Read, Write;
    logic [4:0]  operation;
    logic        Run, IllegalOp, MemFault;
    logic [3:0]  Tstep;
    logic [23:0] strobes;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    assign strobes = {PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, BAout, Rout,
                      MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
                      GRA, GRB, GRC, IncPC, Read, Write};

    control_sequencer #(.OPW(5), .MEM_WAIT_MAX(15)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .MemReady(MemReady),
        .Stop(Stop), .Start(Start),
        .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin),
        .GRA(GRA), .GRB(GRB), .GRC(GRC), .IncPC(IncPC), .Read(Read), .Write(Write),
        .operation(operation), .Run(Run), .Tstep(Tstep),
        .IllegalOp(IllegalOp), .MemFault(MemFault)
    );

    // Clock / reset block.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ev(input int t, input int op, input logic [23:0] s);
        return {4'(t), 5'(op), s};
    endfunction

    // Scoreboard drain: compare current outputs to each expected entry, stepping between them.
    task automatic drain(input string tag);
        int n;
        logic [W-1:0] e;
        n = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_%0d", tag, n), {Tstep, operation, strobes}, e);
            n++;
            if (exp_q.size() != 0) step();
        end
    endtask

    initial begin
        Reset_n = 1'b0; IR = IR_ADD; MemReady = 1'b1; Stop = 1'b0; Start = 1'b0;
        step();
        step();
        chk("por_outputs", {Tstep, operation, strobes}, ev(0, 0, 24'h0));
        chk("por_run", Run, 1);
        chk("por_memfault", MemFault, 0);
        Reset_n = 1'b1;
        #1;

        // Run ADD up to T4, then reset in the middle of T4.
        exp_q.push_back(ev(0, 0, S_T0));
        exp_q.push_back(ev(1, 0, S_T1));
        exp_q.push_back(ev(2, 0, S_T2));
        exp_q.push_back(ev(3, 0, B_GRB | B_ROUT | B_YIN));
        exp_q.push_back(ev(4, 3, B_GRC | B_ROUT | B_ZIN));
        drain("pre_rst");
        Reset_n = 1'b0;
        #1;
        chk("midrst_outputs", {Tstep, operation, strobes}, ev(0, 0, 24'h0));
        chk("midrst_run", Run, 1);
        step();
        Reset_n = 1'b1;
        #1;

        // Full ADD R4,R0,R0 after reset release.
        exp_q.push_back(ev(0, 0, S_T0));
        exp_q.push_back(ev(1, 0, S_T1));
        exp_q.push_back(ev(2, 0, S_T2));
        exp_q.push_back(ev(3, 0, B_GRB | B_ROUT | B_YIN));
        exp_q.push_back(ev(4, 3, B_GRC | B_ROUT | B_ZIN));
        exp_q.push_back(ev(5, 0, B_ZLOW | B_GRA | B_RIN));
        exp_q.push_back(ev(0, 0, S_T0));
        drain("add");
        chk("add_run", Run, 1);

        // MFLO R1: single execute step.
        IR = IR_MFLO;
        exp_q.push_back(ev(0, 0, S_T0));
        exp_q.push_back(ev(1, 0, S_T1));
        exp_q.push_back(ev(2, 0, S_T2));
        exp_q.push_back(ev(3, 0, B_GRA | B_RIN | B_LOOUT));
        exp_q.push_back(ev(0, 0, S_T0));
        drain("mflo");

        // LD with MemReady held low for three T6 cycles.
        IR = IR_LD;
        exp_q.push_back(ev(0, 0, S_T0));
        exp_q.push_back(ev(1, 0, S_T1));
        exp_q.push_back(ev(2, 0, S_T2));
        exp_q.push_back(ev(3, 0, B_GRB | B_BAOUT | B_YIN));
        exp_q.push_back(ev(4, 3, B_COUT | B_ZIN));
        exp_q.push_back(ev(5, 0, B_ZLOW | B_MARIN));
        drain("ld_a");
        MemReady = 1'b0;
        step();
        for (int i = 0; i < 3; i++) exp_q.push_back(ev(6, 0, B_READ | B_MDRIN));
        drain("ld_wait");
        step();
        MemReady = 1'b1;
        exp_q.push_back(ev(6, 0, B_READ | B_MDRIN));
        exp_q.push_back(ev(7, 0, B_MDROUT | B_GRA | B_RIN));
        exp_q.push_back(ev(0, 0, S_T0));
        drain("ld_b");

        // Memory timeout in T1: 15 stalled cycles, then HALT with MemFault.
        MemReady = 1'b0;
        step();
        for (int i = 0; i < 14; i++) step();
        chk("to_still_t1", {Tstep, operation, strobes}, ev(1, 0, S_T1));
        chk("to_nofault_yet", MemFault, 0);
        step();
        chk("to_memfault", MemFault, 1);
        chk("to_run", Run, 0);
        chk("to_strobes", {operation, strobes}, 29'h0);
        step();
        step();
        chk("to_stays_halted", Run, 0);
        chk("to_fault_sticky", MemFault, 1);
        MemReady = 1'b1;
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("to_start_t0", {Tstep, operation, strobes}, ev(0, 0, S_T0));
        chk("to_start_run", Run, 1);
        chk("to_start_clear", MemFault, 0);

        // Illegal opcode with Stop held: IllegalOp pulse, then HALT.
        IR = IR_ILL;
        Stop = 1'b1;
        step();
        step();
        step();
        chk("ill_t3", {Tstep, operation, strobes}, ev(3, 0, 24'h0));
        chk("ill_pulse", IllegalOp, 1);
        step();
        chk("ill_pulse_end", IllegalOp, 0);
        chk("ill_halt_run", Run, 0);
        chk("ill_halt_strobes", {operation, strobes}, 29'h0);
        Start = 1'b1;
        step();
        Start = 1'b0;
        Stop = 1'b0;
        chk("startwins_run", Run, 1);
        chk("startwins_t0", {Tstep, operation, strobes}, ev(0, 0, S_T0));

        // HALT opcode; a Start outside HALT is ignored.
        IR = IR_HALT;
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("start_ignored", {Tstep, operation, strobes}, ev(1, 0, S_T1));
        step();
        step();
        chk("halt_t3", Tstep, 3);
        step();
        chk("halt_op_run", Run, 0);
        chk("halt_op_strobes", {operation, strobes}, 29'h0);
        step();
        chk("halt_op_stays", Run, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
